mul_rs_issue: RTL and testbench

MUL_RS_ISSUE -- requirements
Module: mul_rs_issue

---
 rtl/mul_rs_issue.sv | 242 ++++++++++++++++++++++++
 tb/tb_mul_rs_issue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rs_issue.sv
// Mul/div reservation station: allocation, CDB wakeup, single exec-unit issue.
// Optional macro MULRS_DIV0_TRAP_EN traps divide-by-zero (div0_v) instead of dispatching it.
module mul_rs_issue #(
    parameter int NUM_ENT = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        alloc_v,
    input  logic [3:0]  alloc_func,
    input  logic [3:0]  alloc_rd,
    input  logic [2:0]  alloc_rob,
    input  logic        alloc_src1_rdy,
    input  logic        alloc_src2_rdy,
    input  logic [2:0]  alloc_src1_tag,
    input  logic [2:0]  alloc_src2_tag,
    input  logic [7:0]  alloc_src1_data,
    input  logic [7:0]  alloc_src2_data,
    output logic        alloc_ready,
    input  logic        cdb_v,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    output logic        ex_b,
    output logic [2:0]  rs_index,
    output logic [7:0]  rs1_data,
    output logic [7:0]  rs2_data,
    output logic [3:0]  func,
    output logic [3:0]  rd,
    output logic [2:0]  rob_ind,
    input  logic        exec_done,
    input  logic [2:0]  exec_done_idx,
    output logic [2:0]  mulcount,
    output logic        alloc_err,
    output logic        div0_v,
    output logic [2:0]  div0_rob
);

    localparam int DATA_W = 8;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    // Entry control state
    logic [NUM_ENT-1:0] ent_v;
    logic [NUM_ENT-1:0] ent_exec;
    logic [NUM_ENT-1:0] ent_r1;
    logic [NUM_ENT-1:0] ent_r2;

    // Entry payload
    logic [3:0]        ent_func [NUM_ENT];
    logic [3:0]        ent_rd   [NUM_ENT];
    logic [2:0]        ent_rob  [NUM_ENT];
    logic [2:0]        ent_t1   [NUM_ENT];
    logic [2:0]        ent_t2   [NUM_ENT];
    logic [DATA_W-1:0] ent_d1   [NUM_ENT];
    logic [DATA_W-1:0] ent_d2   [NUM_ENT];

    logic        busy;
    logic [2:0]  count;
    logic        err_q;

    // Operand/command hold registers presented to the exec unit while it runs
    logic [2:0]        h_idx;
    logic [DATA_W-1:0] h_d1;
    logic [DATA_W-1:0] h_d2;
    logic [3:0]        h_func;
    logic [3:0]        h_rd;
    logic [2:0]        h_rob;

    logic              free_found;
    logic [2:0]        free_idx;
    logic              sel_found;
    logic [2:0]        sel_idx;
    logic [3:0]        sel_func;
    logic [3:0]        sel_rd;
    logic [2:0]        sel_rob;
    logic [DATA_W-1:0] sel_d1;
    logic [DATA_W-1:0] sel_d2;
    logic              done_hit;

    logic              func_legal;
    logic              alloc_take;
    logic              a1_rdy;
    logic              a2_rdy;
    logic [DATA_W-1:0] a1_data;
    logic [DATA_W-1:0] a2_data;
    logic [DATA_W-1:0] cdb_lo;
    logic              dispatch_go;
    logic              div0_hit;
    logic              done_ok;
    logic [2:0]        count_nxt;
    logic              unused_cdb_hi;

    assign cdb_lo        = cdb_data[DATA_W-1:0];
    assign unused_cdb_hi = ^cdb_data[15:DATA_W];

    // Lowest free entry, lowest dispatchable entry and completion match
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_func   = '0;
        sel_rd     = '0;
        sel_rob    = '0;
        sel_d1     = '0;
        sel_d2     = '0;
        done_hit   = 1'b0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (!ent_v[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
            if (ent_v[i] && !ent_exec[i] && ent_r1[i] && ent_r2[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
                sel_func  = ent_func[i];
                sel_rd    = ent_rd[i];
                sel_rob   = ent_rob[i];
                sel_d1    = ent_d1[i];
                sel_d2    = ent_d2[i];
            end
            if (ent_exec[i] && exec_done_idx == 3'(i)) begin
                done_hit = 1'b1;
            end
        end
    end

    assign alloc_ready = free_found;
    assign func_legal  = (alloc_func == FUNC_MUL) || (alloc_func == FUNC_DIV);
    assign alloc_take  = alloc_v && alloc_ready && func_legal;

    // A source arriving on the CDB in the allocation cycle is stored as ready
    assign a1_rdy  = alloc_src1_rdy || (cdb_v && alloc_src1_tag == cdb_tag);
    assign a2_rdy  = alloc_src2_rdy || (cdb_v && alloc_src2_tag == cdb_tag);
    assign a1_data = alloc_src1_rdy ? alloc_src1_data : cdb_lo;
    assign a2_data = alloc_src2_rdy ? alloc_src2_data : cdb_lo;

    assign dispatch_go = sel_found && !busy && !rst;
    assign done_ok     = exec_done && busy && done_hit;

`ifdef MULRS_DIV0_TRAP_EN
    assign div0_hit = dispatch_go && (sel_func == FUNC_DIV) && (sel_d2 == '0);
`else
    assign div0_hit = 1'b0;
`endif

    assign ex_b     = dispatch_go && !div0_hit;
    assign div0_v   = div0_hit;
    assign div0_rob = div0_hit ? sel_rob : 3'd0;

    // Dispatch cycle shows the selected entry; afterwards the held copy
    assign rs_index = ex_b ? sel_idx  : h_idx;
    assign rs1_data = ex_b ? sel_d1   : h_d1;
    assign rs2_data = ex_b ? sel_d2   : h_d2;
    assign func     = ex_b ? sel_func : h_func;
    assign rd       = ex_b ? sel_rd   : h_rd;
    assign rob_ind  = ex_b ? sel_rob  : h_rob;

    assign mulcount  = count;
    assign alloc_err = err_q;

    assign count_nxt = count + {2'b00, alloc_take} - {2'b00, (done_ok || div0_hit)};

    always_ff @(posedge clk1) begin
        if (rst) begin
            ent_v    <= '0;
            ent_exec <= '0;
            ent_r1   <= '0;
            ent_r2   <= '0;
            busy     <= 1'b0;
            count    <= '0;
            err_q    <= 1'b0;
            h_idx    <= '0;
            h_d1     <= '0;
            h_d2     <= '0;
            h_func   <= '0;
            h_rd     <= '0;
            h_rob    <= '0;
        end else begin
            err_q <= alloc_v && !func_legal;
            count <= count_nxt;
            for (int i = 0; i < NUM_ENT; i++) begin
                if (alloc_take && free_idx == 3'(i)) begin
                    ent_v[i]    <= 1'b1;
                    ent_exec[i] <= 1'b0;
                    ent_r1[i]   <= a1_rdy;
                    ent_r2[i]   <= a2_rdy;
                end else begin
                    if (cdb_v && ent_v[i] && !ent_r1[i] && ent_t1[i] == cdb_tag) begin
                        ent_r1[i] <= 1'b1;
                    end
                    if (cdb_v && ent_v[i] && !ent_r2[i] && ent_t2[i] == cdb_tag) begin
                        ent_r2[i] <= 1'b1;
                    end
                    if (done_ok && exec_done_idx == 3'(i)) begin
                        ent_v[i]    <= 1'b0;
                        ent_exec[i] <= 1'b0;
                    end
                    if (ex_b && sel_idx == 3'(i)) begin
                        ent_exec[i] <= 1'b1;
                    end
                    if (div0_hit && sel_idx == 3'(i)) begin
                        ent_v[i] <= 1'b0;
                    end
                end
            end
            if (ex_b) begin
                busy   <= 1'b1;
                h_idx  <= sel_idx;
                h_d1   <= sel_d1;
                h_d2   <= sel_d2;
                h_func <= sel_func;
                h_rd   <= sel_rd;
                h_rob  <= sel_rob;
            end else if (done_ok) begin
                busy <= 1'b0;
            end
        end
    end

    // Payload carries no reset; validity is governed by ent_v
    always_ff @(posedge clk1) begin
        for (int i = 0; i < NUM_ENT; i++) begin
            if (alloc_take && free_idx == 3'(i)) begin
                ent_func[i] <= alloc_func;
                ent_rd[i]   <= alloc_rd;
                ent_rob[i]  <= alloc_rob;
                ent_t1[i]   <= alloc_src1_tag;
                ent_t2[i]   <= alloc_src2_tag;
                ent_d1[i]   <= a1_data;
                ent_d2[i]   <= a2_data;
            end else begin
                if (cdb_v && ent_v[i] && !ent_r1[i] && ent_t1[i] == cdb_tag) begin
                    ent_d1[i] <= cdb_lo;
                end
                if (cdb_v && ent_v[i] && !ent_r2[i] && ent_t2[i] == cdb_tag) begin
                    ent_d2[i] <= cdb_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_rs_issue.sv
// Directed scoreboard bench for mul_rs_issue: expected dispatches are queued,
// a negedge monitor pops and compares them whenever ex_b is seen.
module tb_mul_rs_issue;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        alloc_v;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic [2:0]  alloc_rob;
    logic        alloc_src1_rdy;
    logic        alloc_src2_rdy;
    logic [2:0]  alloc_src1_tag;
    logic [2:0]  alloc_src2_tag;
    logic [7:0]  alloc_src1_data;
    logic [7:0]  alloc_src2_data;
    logic        alloc_ready;
    logic        cdb_v;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        ex_b;
    logic [2:0]  rs_index;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [2:0]  rob_ind;
    logic        exec_done;
    logic [2:0]  exec_done_idx;
    logic [2:0]  mulcount;
    logic        alloc_err;
    logic        div0_v;
    logic [2:0]  div0_rob;

    int checks = 0;
    int errors = 0;

    logic [29:0] exp_q[$];
    logic [29:0] exp_rec;
    logic [29:0] act_rec;

    mul_rs_issue #(.NUM_ENT(3)) dut (
        .clk1(clk1), .rst(rst),
        .alloc_v(alloc_v), .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
        .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
        .alloc_ready(alloc_ready), .cdb_v(cdb_v), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .func(func), .rd(rd), .rob_ind(rob_ind),
        .exec_done(exec_done), .exec_done_idx(exec_done_idx),
        .mulcount(mulcount), .alloc_err(alloc_err), .div0_v(div0_v), .div0_rob(div0_rob)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: every dispatch must match the head of the expectation queue
    always @(negedge clk1) begin
        if (rst === 1'b0 && ex_b === 1'b1) begin
            checks++;
            act_rec = {rs_index, rs1_data, rs2_data, func, rd, rob_ind};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dispatch_unexpected got idx=%0d rs1=%0d rs2=%0d func=%b required none",
                         rs_index, rs1_data, rs2_data, func);
            end else begin
                exp_rec = exp_q.pop_front();
                if (act_rec !== exp_rec) begin
                    errors++;
                    $display("FAIL dispatch got idx/rs1/rs2/func/rd/rob=%h required %h", act_rec, exp_rec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob);
        exp_q.push_back({idx, d1, d2, f, r, rob});
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic [3:0] r, input logic [2:0] rob,
                            input logic r1, input logic [2:0] t1, input logic [7:0] d1,
                            input logic r2, input logic [2:0] t2, input logic [7:0] d2);
        alloc_v = 1'b1;
        alloc_func = f;
        alloc_rd = r;
        alloc_rob = rob;
        alloc_src1_rdy = r1;
        alloc_src1_tag = t1;
        alloc_src1_data = d1;
        alloc_src2_rdy = r2;
        alloc_src2_tag = t2;
        alloc_src2_data = d2;
        tick();
        alloc_v = 1'b0;
    endtask

    task automatic finish_exec(input logic [2:0] idx);
        exec_done = 1'b1;
        exec_done_idx = idx;
        tick();
        exec_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alloc_v = 0; alloc_func = 0; alloc_rd = 0; alloc_rob = 0;
        alloc_src1_rdy = 0; alloc_src2_rdy = 0; alloc_src1_tag = 0; alloc_src2_tag = 0;
        alloc_src1_data = 0; alloc_src2_data = 0;
        cdb_v = 0; cdb_tag = 0; cdb_data = 0; exec_done = 0; exec_done_idx = 0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_mulcount", 32'(mulcount), 0);
        check("reset_alloc_ready", 32'(alloc_ready), 1);
        check("reset_ex_b", 32'(ex_b), 0);
        check("reset_outputs", {rs_index, rs1_data, rs2_data, func, rd, rob_ind}, 0);
        check("reset_err_div0", {alloc_err, div0_v, div0_rob}, 0);

        // Basic mul dispatch
        push_exp(3'd0, 8'd3, 8'd4, 4'b0010, 4'd5, 3'd2);
        do_alloc(4'b0010, 4'd5, 3'd2, 1, 3'd0, 8'd3, 1, 3'd0, 8'd4);
        check("mul_ex_b", 32'(ex_b), 1);
        check("mul_mulcount", 32'(mulcount), 1);
        tick();
        tick();
        check("hold_ex_b_low", 32'(ex_b), 0);
        check("hold_operands", {rs_index, rs1_data, rs2_data, func}, {3'd0, 8'd3, 8'd4, 4'b0010});
        finish_exec(3'd0);
        check("mul_done_mulcount", 32'(mulcount), 0);

        // Div waiting on CDB
        push_exp(3'd0, 8'd10, 8'd2, 4'b0011, 4'd7, 3'd1);
        do_alloc(4'b0011, 4'd7, 3'd1, 1, 3'd0, 8'd10, 0, 3'd6, 8'hEE);
        check("div_wait_ex_b", 32'(ex_b), 0);
        cdb_v = 1; cdb_tag = 3'd6; cdb_data = 16'h0002;
        tick();
        cdb_v = 0;
        check("div_wake_ex_b", 32'(ex_b), 1);
        check("div_wake_rs2", 32'(rs2_data), 2);
        tick();
        finish_exec(3'd0);

        // Fill the station behind a busy exec unit
        push_exp(3'd0, 8'd2, 8'd3, 4'b0010, 4'd1, 3'd0);
        do_alloc(4'b0010, 4'd1, 3'd0, 1, 3'd0, 8'd2, 1, 3'd0, 8'd3);
        push_exp(3'd1, 8'd4, 8'd5, 4'b0010, 4'd2, 3'd1);
        do_alloc(4'b0010, 4'd2, 3'd1, 1, 3'd0, 8'd4, 1, 3'd0, 8'd5);
        do_alloc(4'b0011, 4'd3, 3'd2, 1, 3'd0, 8'd6, 1, 3'd0, 8'd7);
        check("full_alloc_ready", 32'(alloc_ready), 0);
        check("full_mulcount", 32'(mulcount), 3);
        do_alloc(4'b0010, 4'd9, 3'd7, 1, 3'd0, 8'd99, 1, 3'd0, 8'd98);
        check("ignored_alloc_mulcount", 32'(mulcount), 3);
        finish_exec(3'd0);
        check("free_one_mulcount", 32'(mulcount), 2);
        check("entry1_ex_b", 32'(ex_b), 1);
        check("entry1_index", 32'(rs_index), 1);
        tick();
        // Alloc and completion in the same cycle: new entry lands in slot 0 ahead of slot 2
        push_exp(3'd0, 8'd8, 8'd9, 4'b0010, 4'd4, 3'd3);
        push_exp(3'd2, 8'd6, 8'd7, 4'b0011, 4'd3, 3'd2);
        exec_done = 1; exec_done_idx = 3'd1;
        do_alloc(4'b0010, 4'd4, 3'd3, 1, 3'd0, 8'd8, 1, 3'd0, 8'd9);
        exec_done = 0;
        check("alloc_done_mulcount", 32'(mulcount), 2);
        check("alloc_done_index", 32'(rs_index), 0);
        tick();
        finish_exec(3'd2);
        check("stale_done_mulcount", 32'(mulcount), 2);
        check("stale_done_ex_b", 32'(ex_b), 0);
        finish_exec(3'd0);
        check("entry2_mulcount", 32'(mulcount), 1);
        check("entry2_ex_b", 32'(ex_b), 1);
        tick();
        finish_exec(3'd2);
        check("drain_mulcount", 32'(mulcount), 0);

        // Alloc with same-cycle CDB forwarding
        push_exp(3'd0, 8'd9, 8'd5, 4'b0010, 4'd9, 3'd4);
        cdb_v = 1; cdb_tag = 3'd4; cdb_data = 16'hA509;
        do_alloc(4'b0010, 4'd9, 3'd4, 0, 3'd4, 8'hEE, 1, 3'd0, 8'd5);
        cdb_v = 0;
        check("fwd_ex_b", 32'(ex_b), 1);
        check("fwd_rs1", 32'(rs1_data), 9);
        tick();
        finish_exec(3'd0);

        // Illegal func
        do_alloc(4'b0101, 4'd1, 3'd1, 1, 3'd0, 8'd1, 1, 3'd0, 8'd1);
        check("illegal_alloc_err", 32'(alloc_err), 1);
        check("illegal_mulcount", 32'(mulcount), 0);
        tick();
        check("illegal_err_pulse", 32'(alloc_err), 0);

        // Divide by zero
`ifdef MULRS_DIV0_TRAP_EN
        do_alloc(4'b0011, 4'd4, 3'd3, 1, 3'd0, 8'd8, 1, 3'd0, 8'd0);
        check("div0_v", 32'(div0_v), 1);
        check("div0_rob", 32'(div0_rob), 3);
        check("div0_no_ex_b", 32'(ex_b), 0);
        tick();
        check("div0_mulcount", 32'(mulcount), 0);
        check("div0_v_pulse", 32'(div0_v), 0);
`else
        push_exp(3'd0, 8'd8, 8'd0, 4'b0011, 4'd4, 3'd3);
        do_alloc(4'b0011, 4'd4, 3'd3, 1, 3'd0, 8'd8, 1, 3'd0, 8'd0);
        check("div0_off_v", {div0_v, div0_rob}, 0);
        check("div0_off_ex_b", 32'(ex_b), 1);
        tick();
        finish_exec(3'd0);
        check("div0_off_mulcount", 32'(mulcount), 0);
`endif

        // Reset during execution abandons the operation
        push_exp(3'd0, 8'd7, 8'd7, 4'b0010, 4'd1, 3'd5);
        do_alloc(4'b0010, 4'd1, 3'd5, 1, 3'd0, 8'd7, 1, 3'd0, 8'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_mulcount", 32'(mulcount), 0);
        check("midrst_outputs", {ex_b, rs1_data, rd, alloc_ready}, {1'b0, 8'd0, 4'd0, 1'b1});
        do_alloc(4'b0010, 4'd6, 3'd6, 0, 3'd7, 8'd0, 1, 3'd0, 8'd2);
        finish_exec(3'd0);
        check("idle_done_ignored", 32'(mulcount), 1);
        push_exp(3'd0, 8'd3, 8'd2, 4'b0010, 4'd6, 3'd6);
        cdb_v = 1; cdb_tag = 3'd7; cdb_data = 16'h0003;
        tick();
        cdb_v = 0;
        check("post_rst_ex_b", 32'(ex_b), 1);
        tick();
        finish_exec(3'd0);
        check("final_mulcount", 32'(mulcount), 0);
        tick();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
